// File: rtl/packetizer_dta_serial.sv
// rtl/packetizer_dta_serial.sv - serialising NoC packetizer with tag allocation and outstanding counter
// Optional outstanding-transaction throttle: PKT_DTA_OUTSTANDING_LIMIT_EN
module packetizer_dta_serial #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_IN         = 32,
  parameter int TAG_WIDTH        = 8,
  parameter int FLIT_WIDTH       = 36,
  parameter int MAX_OUTSTANDING  = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [WIDTH_IN-1:0]                     data_in,
  input  logic                                    valid_in,
  input  logic [ADDRESS_WIDTH-1:0]                dst_in,
  input  logic [VC_ADDRESS_WIDTH-1:0]             vc_in,
  input  logic [ADDRESS_WIDTH-1:0]                ret_dst_in,
  input  logic [VC_ADDRESS_WIDTH-1:0]             ret_vc_in,
  output logic                                    ready_out,
  output logic [TAG_WIDTH-1:0]                    tag_out,
  input  logic                                    tag_ret_valid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]    outstanding,
  output logic [FLIT_WIDTH-1:0]                   data_out,
  output logic                                    valid_out,
  input  logic                                    ready_in
);

  localparam int PAYLOAD_W = TAG_WIDTH + ADDRESS_WIDTH + VC_ADDRESS_WIDTH + WIDTH_IN;
  localparam int CHUNK_W   = FLIT_WIDTH - 3 - ADDRESS_WIDTH - VC_ADDRESS_WIDTH;
  localparam int CHUNK_S   = (CHUNK_W < 1) ? 1 : CHUNK_W;
  localparam int NUM_FLITS = (PAYLOAD_W + CHUNK_S - 1) / CHUNK_S;
  localparam int PAD_W     = NUM_FLITS * CHUNK_S;
  localparam int CNT_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam int OS_W      = $clog2(MAX_OUTSTANDING + 1);

  if (CHUNK_W < 1) begin : g_chunk_check
    $error("packetizer_dta_serial: FLIT_WIDTH leaves no room for payload");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t                        state;
  logic [CNT_W-1:0]              flit_cnt;
  logic [PAD_W-1:0]              payload_q;
  logic [ADDRESS_WIDTH-1:0]      dst_q;
  logic [VC_ADDRESS_WIDTH-1:0]   vc_q;
  logic [TAG_WIDTH-1:0]          tag_q;
  logic                          credit_ok;
  logic                          last_flit;
  logic                          accept;
  logic [PAD_W-1:0]              new_payload;

  function automatic logic [FLIT_WIDTH-1:0] build_flit(
    input logic [CNT_W-1:0]            k,
    input logic [PAD_W-1:0]            p,
    input logic [ADDRESS_WIDTH-1:0]    d,
    input logic [VC_ADDRESS_WIDTH-1:0] v
  );
    logic [CHUNK_S-1:0] chunk;
    logic               head;
    logic               tail;
    chunk = CHUNK_S'(p >> (int'(k) * CHUNK_S));
    head  = (k == '0);
    tail  = (k == CNT_W'(NUM_FLITS - 1));
    return {1'b1, head, tail, d, v, chunk};
  endfunction

`ifdef PKT_DTA_OUTSTANDING_LIMIT_EN
  assign credit_ok = (outstanding < OS_W'(MAX_OUTSTANDING));
`else
  assign credit_ok = 1'b1;
  logic unused_tag_ret;
  assign unused_tag_ret = tag_ret_valid;
`endif

  assign last_flit   = (flit_cnt == CNT_W'(NUM_FLITS - 1));
  assign ready_out   = credit_ok & ((state == IDLE) | ((state == SEND) & last_flit & ready_in));
  assign accept      = valid_in & ready_out;
  assign tag_out     = tag_q;
  // Zero-extension of the payload gives the last chunk its zero padding.
  assign new_payload = PAD_W'({tag_q, ret_dst_in, ret_vc_in, data_in});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flit_cnt  <= '0;
      payload_q <= '0;
      dst_q     <= '0;
      vc_q      <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (accept) begin
      // Covers both a fresh start from IDLE and a back-to-back reload on the tail flit.
      state     <= SEND;
      flit_cnt  <= '0;
      payload_q <= new_payload;
      dst_q     <= dst_in;
      vc_q      <= vc_in;
      data_out  <= build_flit('0, new_payload, dst_in, vc_in);
      valid_out <= 1'b1;
    end else if (state == SEND && ready_in) begin
      if (last_flit) begin
        state     <= IDLE;
        data_out  <= '0;
        valid_out <= 1'b0;
      end else begin
        flit_cnt <= flit_cnt + CNT_W'(1);
        data_out <= build_flit(flit_cnt + CNT_W'(1), payload_q, dst_q, vc_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else if (accept) begin
      tag_q <= tag_q + TAG_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
`ifdef PKT_DTA_OUTSTANDING_LIMIT_EN
      case ({accept, tag_ret_valid})
        2'b10:   outstanding <= outstanding + OS_W'(1);
        2'b01:   if (outstanding != '0) outstanding <= outstanding - OS_W'(1);
        default: outstanding <= outstanding;
      endcase
`else
      if (accept) outstanding <= outstanding + OS_W'(1);
`endif
    end
  end

endmodule

// File: tb/tb_packetizer_dta_serial.sv
// tb/tb_packetizer_dta_serial.sv - directed self-checking bench for packetizer_dta_serial
module tb_packetizer_dta_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic        valid_in;
  logic [3:0]  dst_in;
  logic        vc_in;
  logic [3:0]  ret_dst_in;
  logic        ret_vc_in;
  logic        ready_out;
  logic [7:0]  tag_out;
  logic        tag_ret_valid;
  logic [1:0]  outstanding;
  logic [35:0] data_out;
  logic        valid_out;
  logic        ready_in;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_tag  = 8'd0;
  logic [1:0]  exp_os   = 2'd0;

  always #5 clk = ~clk;

  packetizer_dta_serial #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .dst_in(dst_in), .vc_in(vc_in), .ret_dst_in(ret_dst_in), .ret_vc_in(ret_vc_in),
    .ready_out(ready_out), .tag_out(tag_out), .tag_ret_valid(tag_ret_valid),
    .outstanding(outstanding), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [35:0] exp_flit(input bit k, input logic [7:0] tag, input logic [31:0] d,
                                           input logic [3:0] dst, input logic vc,
                                           input logic [3:0] rd, input logic rv);
    if (!k) return {3'b110, dst, vc, d[27:0]};
    return {3'b101, dst, vc, 11'd0, tag, rd, rv, d[31:28]};
  endfunction

  task automatic step(input bit acc);
`ifdef PKT_DTA_OUTSTANDING_LIMIT_EN
    if (acc && !tag_ret_valid) exp_os = exp_os + 2'd1;
    else if (!acc && tag_ret_valid && exp_os != 2'd0) exp_os = exp_os - 2'd1;
`else
    if (acc) exp_os = exp_os + 2'd1;
`endif
    if (acc) exp_tag = exp_tag + 8'd1;
    @(posedge clk);
    #2;
  endtask

  task automatic drive_req(input logic [31:0] d, input logic [3:0] dst, input logic vc,
                           input logic [3:0] rd, input logic rv);
    data_in = d; dst_in = dst; vc_in = vc; ret_dst_in = rd; ret_vc_in = rv; valid_in = 1'b1;
  endtask

  logic [31:0] bd [3];
  logic [7:0]  t0;
  int          r_total;

  initial begin
    bd[0] = 32'h0123_4567; bd[1] = 32'h89AB_CDEF; bd[2] = 32'hF0E1_D2C3;
    rst_n = 1'b0; valid_in = 1'b0; data_in = '0; dst_in = '0; vc_in = 1'b0;
    ret_dst_in = '0; ret_vc_in = 1'b0; tag_ret_valid = 1'b0; ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_tag", 64'(tag_out), 64'd0);
    check("rst_os", 64'(outstanding), 64'd0);
    check("rst_ready", 64'(ready_out), 64'd1);

    // single packet, hand-computed flits
    drive_req(32'hDEADBEEF, 4'd3, 1'b1, 4'd5, 1'b0);
    #1;
    check("single_ready", 64'(ready_out), 64'd1);
    check("single_tag", 64'(tag_out), 64'd0);
    step(1);
    valid_in = 1'b0;
    check("single_f0_valid", 64'(valid_out), 64'd1);
    check("single_f0", 64'(data_out), 64'h0_C7EA_DBEEF);
    step(0);
    check("single_f1", 64'(data_out), 64'h0_A700_000AD);
    step(0);
    check("single_idle", 64'(valid_out), 64'd0);
    check("single_os", 64'(outstanding), 64'(exp_os));

    // back-to-back: three requests, six flits without a bubble
    tag_ret_valid = 1'b1;
    t0 = exp_tag;
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin
        check("b2b_valid", 64'(valid_out), 64'd1);
        check("b2b_flit", 64'(data_out),
              64'(exp_flit(bit'((i - 1) % 2), t0 + 8'((i - 1) / 2), bd[(i - 1) / 2], 4'h9, 1'b0, 4'hA, 1'b1)));
      end
      if (i % 2 == 0 && i < 6) begin
        drive_req(bd[i / 2], 4'h9, 1'b0, 4'hA, 1'b1);
        #1;
        check("b2b_ready", 64'(ready_out), 64'd1);
        check("b2b_tag", 64'(tag_out), 64'(t0 + 8'(i / 2)));
        step(1);
      end else begin
        if (i == 6) begin
          valid_in = 1'b0;
          tag_ret_valid = 1'b0;
        end
        #1;
        check("b2b_ready_gap", 64'(ready_out), 64'(i % 2 == 0));
        step(0);
      end
    end
    check("b2b_idle", 64'(valid_out), 64'd0);

    // backpressure on flit 0 for three cycles
    t0 = exp_tag;
    drive_req(32'hCAFE_F00D, 4'h1, 1'b1, 4'h2, 1'b0);
    #1;
    check("bp_ready", 64'(ready_out), 64'd1);
    step(1);
    valid_in = 1'b0;
    ready_in = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("bp_hold", 64'(data_out), 64'(exp_flit(1'b0, t0, 32'hCAFE_F00D, 4'h1, 1'b1, 4'h2, 1'b0)));
      check("bp_ready_low", 64'(ready_out), 64'd0);
      step(0);
    end
    ready_in = 1'b1;
    #1;
    check("bp_release_f0", 64'(data_out), 64'(exp_flit(1'b0, t0, 32'hCAFE_F00D, 4'h1, 1'b1, 4'h2, 1'b0)));
    step(0);
    check("bp_f1", 64'(data_out), 64'(exp_flit(1'b1, t0, 32'hCAFE_F00D, 4'h1, 1'b1, 4'h2, 1'b0)));
    check("bp_f1_ready", 64'(ready_out), 64'd1);
    step(0);
    check("bp_idle", 64'(valid_out), 64'd0);

`ifdef PKT_DTA_OUTSTANDING_LIMIT_EN
    // credit limit with MAX_OUTSTANDING=2
    drive_req(32'h1234_5678, 4'h7, 1'b0, 4'h1, 1'b1);
    #1;
    check("cr_ready", 64'(ready_out), 64'd1);
    step(1);
    valid_in = 1'b0;
    step(0);
    check("cr_last_blocked", 64'(ready_out), 64'd0);
    step(0);
    valid_in = 1'b1;
    #1;
    check("cr_os_full", 64'(outstanding), 64'd2);
    check("cr_idle_blocked", 64'(ready_out), 64'd0);
    tag_ret_valid = 1'b1;
    step(0);
    check("cr_ret_os", 64'(outstanding), 64'd1);
    check("cr_ret_ready", 64'(ready_out), 64'd1);
    step(1);
    check("cr_acc_ret_os", 64'(outstanding), 64'(exp_os));
    valid_in = 1'b0;
    tag_ret_valid = 1'b0;
    step(0);
    step(0);
`else
    // returns are ignored when the limit is compiled out
    tag_ret_valid = 1'b1;
    step(0);
    tag_ret_valid = 1'b0;
    check("nolim_ret_ignored", 64'(outstanding), 64'(exp_os));
`endif

    // tag wrap 255 -> 0
    tag_ret_valid = 1'b1;
    step(0);
    step(0);
    r_total = 257 - int'(exp_tag);
    for (int r = 0; r < r_total; r++) begin
      drive_req(32'(r), 4'h4, 1'b0, 4'h6, 1'b1);
      #1;
      if (exp_tag == 8'hFF) check("wrap_tag_ff", 64'(tag_out), 64'hFF);
      if (r == r_total - 1) check("wrap_tag_0", 64'(tag_out), 64'h0);
      step(1);
      step(0);
    end
    valid_in = 1'b0;
    step(0);
    check("wrap_os", 64'(outstanding), 64'(exp_os));
    step(0);
    check("ret_at_zero_os", 64'(outstanding), 64'(exp_os));
    tag_ret_valid = 1'b0;

    // reset in the middle of a packet
    drive_req(32'h5555_AAAA, 4'h2, 1'b1, 4'h3, 1'b0);
    #1;
    step(1);
    valid_in = 1'b0;
    check("mid_f0_valid", 64'(valid_out), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(valid_out), 64'd0);
    check("mid_rst_data", 64'(data_out), 64'd0);
    exp_tag = 8'd0;
    exp_os  = 2'd0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("mid_tag", 64'(tag_out), 64'(exp_tag));
    check("mid_os", 64'(outstanding), 64'(exp_os));
    check("mid_ready", 64'(ready_out), 64'd1);
    step(0);
    check("mid_no_tail", 64'(valid_out), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
